// File: rtl/ai_move_gen.sv
// Tic-tac-toe move picker: win, then block, then preferred empty cell, one check per cycle.
// Move appears 1..25 cycles after start and is held until move_ready; start is ignored while busy.
module ai_move_gen #(
    parameter logic [1:0] AI_MARK = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] registers,
    input  logic        move_ready,
    output logic        move_valid,
    output logic [1:0]  xoro,
    output logic [1:0]  row,
    output logic [1:0]  col,
    output logic        busy,
    output logic        nomove
);

    localparam logic [1:0] OPP_MARK = {AI_MARK[0], AI_MARK[1]};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WIN,
        S_BLOCK,
        S_PREF,
        S_PRESENT,
        S_FULL
    } state_t;

    state_t      state_q;
    logic [17:0] snap_q;
    logic [3:0]  idx_q;
    logic        move_valid_q;
    logic [1:0]  xoro_q;
    logic [1:0]  row_q;
    logic [1:0]  col_q;
    logic        busy_q;
    logic        nomove_q;

    logic [3:0]  cell_a, cell_b, cell_c;
    logic [1:0]  code_a, code_b, code_c;
    logic [1:0]  scan_mark;
    logic        line_hit;
    logic [3:0]  line_tgt;
    logic [3:0]  pref_cell;
    logic        pref_hit;

    function automatic logic [1:0] cell_code(input logic [17:0] b, input logic [3:0] k);
        return b[{k, 1'b0} +: 2];
    endfunction

    function automatic logic [3:0] cell_to_rc(input logic [3:0] k);
        case (k)
            4'd0:    return {2'd0, 2'd0};
            4'd1:    return {2'd0, 2'd1};
            4'd2:    return {2'd0, 2'd2};
            4'd3:    return {2'd1, 2'd0};
            4'd4:    return {2'd1, 2'd1};
            4'd5:    return {2'd1, 2'd2};
            4'd6:    return {2'd2, 2'd0};
            4'd7:    return {2'd2, 2'd1};
            4'd8:    return {2'd2, 2'd2};
            default: return {2'd0, 2'd0};
        endcase
    endfunction

    // Lines L0..L7: rows, columns, main diagonal, anti-diagonal.
    always_comb begin
        cell_a = 4'd0;
        cell_b = 4'd1;
        cell_c = 4'd2;
        case (idx_q[2:0])
            3'd0: begin cell_a = 4'd0; cell_b = 4'd1; cell_c = 4'd2; end
            3'd1: begin cell_a = 4'd3; cell_b = 4'd4; cell_c = 4'd5; end
            3'd2: begin cell_a = 4'd6; cell_b = 4'd7; cell_c = 4'd8; end
            3'd3: begin cell_a = 4'd0; cell_b = 4'd3; cell_c = 4'd6; end
            3'd4: begin cell_a = 4'd1; cell_b = 4'd4; cell_c = 4'd7; end
            3'd5: begin cell_a = 4'd2; cell_b = 4'd5; cell_c = 4'd8; end
            3'd6: begin cell_a = 4'd0; cell_b = 4'd4; cell_c = 4'd8; end
            default: begin cell_a = 4'd2; cell_b = 4'd4; cell_c = 4'd6; end
        endcase
    end

    // Exact code compares keep 11 from ever counting as either mark.
    always_comb begin
        scan_mark = (state_q == S_BLOCK) ? OPP_MARK : AI_MARK;
        code_a    = cell_code(snap_q, cell_a);
        code_b    = cell_code(snap_q, cell_b);
        code_c    = cell_code(snap_q, cell_c);
        line_hit  = 1'b0;
        line_tgt  = cell_a;
        if (code_a == scan_mark && code_b == scan_mark && code_c == 2'b00) begin
            line_hit = 1'b1;
            line_tgt = cell_c;
        end else if (code_a == scan_mark && code_c == scan_mark && code_b == 2'b00) begin
            line_hit = 1'b1;
            line_tgt = cell_b;
        end else if (code_b == scan_mark && code_c == scan_mark && code_a == 2'b00) begin
            line_hit = 1'b1;
            line_tgt = cell_a;
        end
    end

    // Preference order: centre, corners, edges.
    always_comb begin
        pref_cell = 4'd0;
        case (idx_q)
            4'd0:    pref_cell = 4'd4;
            4'd1:    pref_cell = 4'd0;
            4'd2:    pref_cell = 4'd2;
            4'd3:    pref_cell = 4'd6;
            4'd4:    pref_cell = 4'd8;
            4'd5:    pref_cell = 4'd1;
            4'd6:    pref_cell = 4'd3;
            4'd7:    pref_cell = 4'd5;
            4'd8:    pref_cell = 4'd7;
            default: pref_cell = 4'd0;
        endcase
        pref_hit = (idx_q <= 4'd8) && (cell_code(snap_q, pref_cell) == 2'b00);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            idx_q        <= '0;
            move_valid_q <= 1'b0;
            xoro_q       <= 2'b00;
            row_q        <= 2'b00;
            col_q        <= 2'b00;
            busy_q       <= 1'b0;
            nomove_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        snap_q  <= registers;
                        idx_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_WIN;
                    end
                end
                S_WIN, S_BLOCK: begin
                    if (line_hit) begin
                        {row_q, col_q} <= cell_to_rc(line_tgt);
                        move_valid_q   <= 1'b1;
                        xoro_q         <= AI_MARK;
                        state_q        <= S_PRESENT;
                    end else if (idx_q == 4'd7) begin
                        idx_q   <= 4'd0;
                        state_q <= (state_q == S_WIN) ? S_BLOCK : S_PREF;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                S_PREF: begin
                    // Index 9 is the cycle that concludes every cell was occupied.
                    if (pref_hit) begin
                        {row_q, col_q} <= cell_to_rc(pref_cell);
                        move_valid_q   <= 1'b1;
                        xoro_q         <= AI_MARK;
                        state_q        <= S_PRESENT;
                    end else if (idx_q >= 4'd9) begin
                        nomove_q <= 1'b1;
                        state_q  <= S_FULL;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                S_PRESENT: begin
                    if (move_ready) begin
                        move_valid_q <= 1'b0;
                        xoro_q       <= 2'b00;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                S_FULL: begin
                    nomove_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    move_valid_q <= 1'b0;
                    xoro_q       <= 2'b00;
                    busy_q       <= 1'b0;
                    nomove_q     <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign move_valid = move_valid_q;
    assign xoro       = xoro_q;
    assign row        = row_q;
    assign col        = col_q;
    assign busy       = busy_q;
    assign nomove     = nomove_q;

endmodule

// File: tb/tb_ai_move_gen.sv
// Directed bench for ai_move_gen: expected moves queued at start, checked when the move or nomove appears.
module tb_ai_move_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [17:0] registers = '0;
    logic        move_ready = 1'b0;
    logic        move_valid;
    logic [1:0]  xoro;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        busy;
    logic        nomove;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         nm;
        int         lat;
        logic [1:0] r;
        logic [1:0] c;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ai_move_gen #(.AI_MARK(2'b01)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .registers  (registers),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .xoro       (xoro),
        .row        (row),
        .col        (col),
        .busy       (busy),
        .nomove     (nomove)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] bd(input logic [8:0] xm, input logic [8:0] om, input logic [8:0] im);
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) begin
            if (im[k])      b[2*k +: 2] = 2'b11;
            else if (xm[k]) b[2*k +: 2] = 2'b01;
            else if (om[k]) b[2*k +: 2] = 2'b10;
        end
        return b;
    endfunction

    task automatic run(input string name, input logic [17:0] b, input logic [17:0] b_mid,
                       input bit nm, input int lat_e, input logic [1:0] r_e, input logic [1:0] c_e,
                       input int hold);
        exp_t e;
        exp_t p;
        int   lat;
        p.nm = nm; p.lat = lat_e; p.r = r_e; p.c = c_e;
        exp_q.push_back(p);
        @(negedge clk);
        registers = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        registers = b_mid;
        chk({name, "_busy"}, busy, 1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(move_valid || nomove) && lat < 40);
        e = exp_q.pop_front();
        chk({name, "_latency"}, lat, e.lat);
        chk({name, "_nomove"}, nomove, e.nm);
        chk({name, "_move_valid"}, move_valid, !e.nm);
        if (e.nm) begin
            @(posedge clk);
            #1;
            chk({name, "_nomove_pulse"}, nomove, 0);
            chk({name, "_busy_end"}, busy, 0);
            chk({name, "_no_valid"}, move_valid, 0);
        end else begin
            chk({name, "_xoro"}, xoro, 2'b01);
            chk({name, "_row"}, row, e.r);
            chk({name, "_col"}, col, e.c);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                start = (i % 2 == 0);
                @(posedge clk);
                #1;
                chk({name, "_hold_valid"}, move_valid, 1);
                chk({name, "_hold_rc"}, {xoro, row, col}, {2'b01, e.r, e.c});
            end
            @(negedge clk);
            move_ready = 1'b1;
            start      = 1'b1;
            @(posedge clk);
            #1;
            move_ready = 1'b0;
            start      = 1'b0;
            chk({name, "_hs_valid"}, move_valid, 0);
            chk({name, "_hs_xoro"}, xoro, 0);
            chk({name, "_hs_busy"}, busy, 0);
            @(posedge clk);
            #1;
            chk({name, "_start_at_hs_ignored"}, busy, 0);
        end
    endtask

    initial begin
        int bad;
        #1;
        chk("reset_outputs", {move_valid, busy, nomove, xoro, row, col}, 0);
        #20;
        @(negedge clk);
        reset = 1'b1;

        run("empty", 18'h0, 18'h0, 0, 17, 2'd1, 2'd1, 5);
        run("win_l0", bd(9'b000000011, 0, 0), 18'h0, 0, 1, 2'd0, 2'd2, 0);
        run("block_l2", bd(9'b000000001, 9'b011000000, 0), 18'h0, 0, 11, 2'd2, 2'd2, 0);
        run("draw", bd(9'b110001101, 9'b001110010, 0), 18'h0, 1, 26, 2'd0, 2'd0, 0);
        run("win_tie", bd(9'b011000110, 0, 0), 18'h0, 0, 1, 2'd0, 2'd0, 0);
        run("win_l7", bd(9'b000010100, 9'b000001001, 0), 18'h0, 0, 8, 2'd2, 2'd0, 1);
        run("invalid_cells", bd(0, 0, 9'b000010011), 18'h0, 0, 19, 2'd0, 2'd2, 0);
        run("pref_last", bd(0, 0, 9'b101111111), 18'h0, 0, 25, 2'd2, 2'd1, 0);
        run("snapshot", 18'h0, bd(9'b000000011, 0, 0), 0, 17, 2'd1, 2'd1, 0);

        // Abort in BLOCK: outputs must clear without a clock edge.
        @(negedge clk);
        registers = 18'h0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", {move_valid, busy, nomove, xoro, row, col}, 0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (move_valid || nomove || busy) bad++;
        end
        chk("no_output_after_abort", bad, 0);

        run("after_abort", bd(9'b000000011, 0, 0), 18'h0, 0, 1, 2'd0, 2'd2, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ai_move_gen.md
AI_MOVE_GEN -- requirements
Module: ai_move_gen

Interface
REQ-001 SHALL have parameter AI_MARK, default 2'b01 (X), giving the cell code the AI plays; the opponent code SHALL be {AI_MARK[0],AI_MARK[1]}.
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request for one AI move; sampled only in IDLE.
REQ-005 SHALL have port registers  input  18  board state; cell k = 3*row+col occupies bits [2k+1:2k]; 00 empty, 01 X, 10 O, 11 occupied-invalid.
REQ-006 SHALL have port move_ready  input  1  downstream accepts the move.
REQ-007 SHALL have port move_valid  output  1  move on xoro/row/col is valid.
REQ-008 SHALL have port xoro  output  2  AI_MARK while move_valid=1, else 00.
REQ-009 SHALL have port row  output  2  chosen row, 00..10, never 11.
REQ-010 SHALL have port col  output  2  chosen column, 00..10, never 11.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port nomove  output  1  one-cycle pulse when no empty cell exists.

Function
REQ-013 SHALL implement states IDLE, WIN, BLOCK, PREF, PRESENT, FULL.
REQ-014 In IDLE with start=1, SHALL capture registers into an internal snapshot, clear the scan index and enter WIN; registers is not sampled again until the next accepted start.
REQ-015 SHALL evaluate one line per cycle in WIN, in order L0..L7 = rows 0,1,2; cols 0,1,2; diag 0-4-8; anti-diag 2-4-6.
REQ-016 A line SHALL hit in WIN when exactly two of its cells equal AI_MARK and the third is 00; the target is the empty cell.
REQ-017 On a hit SHALL latch the target row/col and enter PRESENT at the next edge; the lowest line index wins ties.
REQ-018 After L7 without a hit, SHALL enter BLOCK, reset the index, and scan L0..L7 identically using the opponent code.
REQ-019 After BLOCK without a hit, SHALL enter PREF and test one cell per cycle in order 4, 0, 2, 6, 8, 1, 3, 5, 7; the first 00 cell is the target and SHALL enter PRESENT.
REQ-020 Code 11 SHALL count as occupied and never match AI_MARK or the opponent code.
REQ-021 If PREF finds no empty cell, SHALL enter FULL for exactly one cycle with nomove=1, then return to IDLE; move_valid stays 0.
REQ-022 Latency: move_valid SHALL rise N edges after the start-accepting edge, N = number of line/cell checks performed (WIN hit at Li: i+1; BLOCK hit at Li: 9+i; PREF hit at position p (0-based): 17+p).
REQ-023 In PRESENT, move_valid=1 and xoro/row/col SHALL be held stable until move_ready=1 is sampled; on that edge SHALL return to IDLE, with move_valid=0 from that edge on.
REQ-024 start SHALL be ignored whenever busy=1, including in PRESENT and FULL.
REQ-025 A start sampled on the same edge that completes a handshake SHALL be ignored; a new request needs start=1 in IDLE.
REQ-026 The index counter SHALL be 4 bits and SHALL not wrap: it is reset on every WIN->BLOCK and BLOCK->PREF transition.
REQ-027 Changes on registers during a scan SHALL have no effect on the chosen move.

Reset
REQ-028 reset=0 SHALL, asynchronously, force IDLE, index 0, and move_valid=0, busy=0, nomove=0, xoro=00, row=00, col=00.
REQ-029 reset asserted mid-scan or in PRESENT SHALL abort the move; no move_valid or nomove SHALL follow release.
REQ-030 After reset release, the first rising edge with start=1 SHALL start a scan.

Verification
REQ-031 Empty board (18'h0), start one cycle -> move_valid=1 17 edges later, xoro=01, row=01, col=01.
REQ-032 X at cells 0 and 1, rest empty -> move_valid 1 edge after start, row=00, col=10.
REQ-033 O at cells 6 and 7, X at cell 0, rest empty -> BLOCK hit at L2, move_valid 11 edges after start, row=10, col=10.
REQ-034 Full draw board (X,O,X / X,O,O / O,X,X) -> nomove=1 for one cycle 26 edges after start, move_valid never 1, busy=0 afterwards.
REQ-035 PRESENT with move_ready=0 for 5 cycles and start pulsed -> outputs stable, start ignored; move_ready=1 -> move_valid=0 after that edge.
REQ-036 reset=0 during BLOCK -> all outputs 0 immediately, without waiting for a clock edge; after release no move_valid until a new start.
